// File: rtl/dwn_timer_pkg.sv
// Shared types for the down-counting timer: FSM state encoding.
package dwn_timer_pkg;

   localparam int ST_W = 2;

   // 2'b11 is deliberately unassigned; the FSM treats it as illegal and returns to IDLE.
   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/dwn_timer_if.sv
// Control/status bundle of the down-counting timer; the controller side is master.
interface dwn_timer_if #(
   parameter int WIDTH = 8
);
   logic             LD;
   logic [WIDTH-1:0] D;
   logic             MODE;
   logic             E;
   logic [WIDTH-1:0] Q;
   logic             TC;
   logic             BUSY;
   logic             DONE;

   modport master (output LD, D, MODE, E, input Q, TC, BUSY, DONE);
   modport slave  (input LD, D, MODE, E, output Q, TC, BUSY, DONE);
endinterface

// File: rtl/dwn_timer_borrow_chain.sv
// Q-1 built from a ripple of adder_carry cells adding all-ones.
module dwn_timer_borrow_chain #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] dec_o
);

   logic [WIDTH-1:0] cin;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;

   assign cin[0] = 1'b0;

   // Each cell adds a constant 1 bit: propagate = ~a, generate = a.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         assign p[gi]     = ~a_i[gi];
         assign g[gi]     = a_i[gi];
         assign dec_o[gi] = p[gi] ^ cin[gi];
         if (gi < WIDTH - 1) begin : g_carry
            assign cin[gi+1] = g[gi] | (p[gi] & cin[gi]);
         end
      end
   endgenerate

endmodule

// File: rtl/dwn_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a one-cycle TC pulse.
module dwn_timer
   import dwn_timer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic        C,
   input  logic        R,
   dwn_timer_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             mode_q, mode_d;
   logic             tc_q, tc_d;
   logic [WIDTH-1:0] q_dec;
   logic             q_is_one;

   dwn_timer_borrow_chain #(.WIDTH(WIDTH)) u_borrow (
      .a_i   (q_q),
      .dec_o (q_dec)
   );

   assign q_is_one = (q_q == WIDTH'(1));

   always_ff @(posedge C) begin
      if (R) begin
         state_q  <= ST_IDLE;
         q_q      <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         tc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         tc_q     <= tc_d;
      end
   end

   // A load always wins over the count, so TC cannot fire on the same edge as LD.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      tc_d     = 1'b0;
      if (bus.LD) begin
         q_d      = bus.D;
         reload_d = bus.D;
         mode_d   = bus.MODE;
         state_d  = (bus.D != '0) ? ST_RUN : ST_IDLE;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (bus.E) begin
                  if (q_is_one) begin
                     tc_d = 1'b1;
                     if (mode_q) begin
                        q_d = reload_q;
                     end else begin
                        q_d     = '0;
                        state_d = ST_DONE;
                     end
                  end else begin
                     q_d = q_dec;
                  end
               end
            end
            ST_IDLE, ST_DONE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.Q    = q_q;
      bus.TC   = tc_q;
      bus.BUSY = (state_q == ST_RUN);
      bus.DONE = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_dwn_timer.sv
// Directed scoreboard bench for dwn_timer: one expected output tuple is queued per clock edge.
module tb_dwn_timer;

   typedef struct {
      logic [7:0] q;
      logic       tc;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   tx = 0;
   exp_t sb[$];
   exp_t mon_e;

   dwn_timer_if #(.WIDTH(8)) bus ();

   dwn_timer #(.WIDTH(8)) dut (
      .C   (clk),
      .R   (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Monitor: outputs are stable at negedge; one queued entry per elapsed posedge.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         checks++;
         tx++;
         if (bus.Q !== mon_e.q || bus.TC !== mon_e.tc ||
             bus.BUSY !== mon_e.busy || bus.DONE !== mon_e.done) begin
            failures++;
            $display("FAIL %s: got q=%0d tc=%0b busy=%0b done=%0b, want q=%0d tc=%0b busy=%0b done=%0b",
                     mon_e.name, bus.Q, bus.TC, bus.BUSY, bus.DONE,
                     mon_e.q, mon_e.tc, mon_e.busy, mon_e.done);
         end else begin
            $display("[tx %0d] %s q=%0d tc=%0b busy=%0b done=%0b ok",
                     tx, mon_e.name, bus.Q, bus.TC, bus.BUSY, bus.DONE);
         end
      end
   end

   task automatic step(input logic r, input logic ld, input logic [7:0] d,
                       input logic mode, input logic e,
                       input logic [7:0] eq, input logic etc,
                       input logic ebusy, input logic edone, input string nm);
      exp_t x;
      rst      = r;
      bus.LD   = ld;
      bus.D    = d;
      bus.MODE = mode;
      bus.E    = e;
      @(posedge clk);
      x.q = eq; x.tc = etc; x.busy = ebusy; x.done = edone; x.name = nm;
      sb.push_back(x);
      @(negedge clk);
   endtask

   initial begin
      bus.LD = 1'b0; bus.D = '0; bus.MODE = 1'b0; bus.E = 1'b0;

      // 1: reset, then enable with no load keeps Q at zero
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, "reset1");
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_e0");
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "idle_e1");

      // 2: one-shot from 3
      step(0, 1, 3, 0, 1, 3, 0, 1, 0, "os_ld3");
      step(0, 0, 0, 0, 1, 2, 0, 1, 0, "os_q2");
      step(0, 0, 0, 0, 1, 1, 0, 1, 0, "os_q1");
      step(0, 0, 0, 0, 1, 0, 1, 0, 1, "os_tc");
      step(0, 0, 0, 0, 1, 0, 0, 0, 1, "os_hold0");
      step(0, 0, 0, 0, 1, 0, 0, 0, 1, "os_hold1");

      // 3: auto-reload of 4 over 12 enabled cycles
      step(0, 1, 4, 1, 1, 4, 0, 1, 0, "ar_ld4");
      for (int k = 1; k <= 12; k++) begin
         if (k % 4 == 0) step(0, 0, 0, 0, 1, 4, 1, 1, 0, "ar_tc");
         else            step(0, 0, 0, 0, 1, 8'(4 - (k % 4)), 0, 1, 0, "ar_cnt");
      end

      // 4: gated count from 5 with E toggling
      step(0, 1, 5, 0, 0, 5, 0, 1, 0, "gt_ld5");
      step(0, 0, 0, 0, 1, 4, 0, 1, 0, "gt_e1");
      step(0, 0, 0, 0, 0, 4, 0, 1, 0, "gt_e0");
      step(0, 0, 0, 0, 1, 3, 0, 1, 0, "gt_e1");
      step(0, 0, 0, 0, 0, 3, 0, 1, 0, "gt_e0");
      step(0, 0, 0, 0, 1, 2, 0, 1, 0, "gt_e1");
      step(0, 0, 0, 0, 0, 2, 0, 1, 0, "gt_e0");
      step(0, 0, 0, 0, 1, 1, 0, 1, 0, "gt_e1");
      step(0, 0, 0, 0, 0, 1, 0, 1, 0, "gt_e0");
      step(0, 0, 0, 0, 1, 0, 1, 0, 1, "gt_tc");
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, "gt_done");

      // 5: reload at terminal count suppresses TC, then abort by reset
      step(0, 1, 2, 0, 1, 2, 0, 1, 0, "rs_ld2");
      step(0, 0, 0, 0, 1, 1, 0, 1, 0, "rs_q1");
      step(0, 1, 9, 0, 1, 9, 0, 1, 0, "rs_ld9_at_tc");
      step(0, 0, 0, 0, 1, 8, 0, 1, 0, "rs_q8");
      step(0, 0, 0, 0, 1, 7, 0, 1, 0, "rs_q7");
      step(1, 0, 0, 0, 1, 0, 0, 0, 0, "rs_abort");
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, "rs_after");

      // 6: maximum period, then a zero load never times out
      step(0, 1, 255, 0, 1, 255, 0, 1, 0, "mx_ld255");
      for (int k = 1; k <= 255; k++) begin
         if (k == 255) step(0, 0, 0, 0, 1, 0, 1, 0, 1, "mx_tc");
         else          step(0, 0, 0, 0, 1, 8'(255 - k), 0, 1, 0, "mx_cnt");
      end
      step(0, 1, 0, 1, 1, 0, 0, 0, 0, "z_ld0");
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1, 0, 0, 0, 0, "z_idle");

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
